// File: rtl/cla_seq_pkg.sv
// Shared types and pin map for the nibble-serial CLA add/subtract sequencer.
package cla_seq_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // uio_in bit positions
  localparam int unsigned UioStart    = 0;
  localparam int unsigned UioSub      = 1;
  localparam int unsigned UioInValid  = 2;
  localparam int unsigned UioAbort    = 3;
  // uio_out bit positions
  localparam int unsigned UioBusy     = 4;
  localparam int unsigned UioOutValid = 5;
  localparam int unsigned UioDone     = 6;
  localparam int unsigned UioCarryOut = 7;

  localparam logic [7:0] UioOeMask = 8'hF0;

endpackage

// File: rtl/cla_seq_if.sv
// Tiny Tapeout tile pin bundle; the tile itself is the slave side.
interface cla_seq_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/cla4.sv
// Combinational 4-bit carry-lookahead adder; also exposes the carry into bit 3.
module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic       c3_o
);
  logic [3:0] g, p;
  logic [4:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = cin_i;
    c[1] = g[0] | (p[0] & cin_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & cin_i);
    sum_o  = p ^ c[3:0];
    cout_o = c[4];
    c3_o   = c[3];
  end
endmodule

// File: rtl/tt_um_cla_seq.sv
// Multi-precision add/subtract sequencer: one nibble per beat through a single cla4.
module tt_um_cla_seq
  import cla_seq_pkg::*;
#(
  parameter int unsigned Nibbles = 4
) (
  input logic     clk,
  input logic     rst_n,
  cla_seq_if.slave bus
);
  localparam logic [1:0] LastIdx = 2'(Nibbles - 1);

  state_e     state_q, state_d;
  logic       carry_q, carry_d;
  logic [1:0] count_q, count_d;
  logic       sub_q, sub_d;
  logic       zero_q, zero_d;
  logic       ovf_q, ovf_d;
  logic       cout_q, cout_d;
  logic [3:0] res_q, res_d;
  logic [1:0] idx_q, idx_d;
  logic       out_valid_q, out_valid_d;
  logic       done_q, done_d;

  logic       start, sub_in, in_valid, abort;
  logic [3:0] sum;
  logic       cout4, c3;
  logic       unused_uio;

  assign start      = bus.uio_in[UioStart];
  assign sub_in     = bus.uio_in[UioSub];
  assign in_valid   = bus.uio_in[UioInValid];
  assign abort      = bus.uio_in[UioAbort];
  assign unused_uio = ^bus.uio_in[7:4];

  cla4 u_cla4 (
    .a_i   (bus.ui_in[3:0]),
    .b_i   (bus.ui_in[7:4] ^ {4{sub_q}}),
    .cin_i (carry_q),
    .sum_o (sum),
    .cout_o(cout4),
    .c3_o  (c3)
  );

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    count_d     = count_q;
    sub_d       = sub_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    cout_d      = cout_q;
    res_d       = res_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    if (abort) begin
      state_d = StIdle;
      carry_d = 1'b0;
      count_d = '0;
      zero_d  = 1'b0;
      ovf_d   = 1'b0;
      cout_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StRun;
            sub_d   = sub_in;
            carry_d = sub_in;  // +1 of two's-complement subtract enters as carry-in
            count_d = '0;
            zero_d  = 1'b1;
            ovf_d   = 1'b0;
            cout_d  = 1'b0;
          end
        end
        StRun: begin
          if (in_valid) begin
            res_d       = sum;
            idx_d       = count_q;
            carry_d     = cout4;
            count_d     = 2'(count_q + 2'd1);
            zero_d      = zero_q & (sum == 4'h0);
            out_valid_d = 1'b1;
            if (count_q == LastIdx) begin
              done_d  = 1'b1;
              cout_d  = cout4;
              ovf_d   = c3 ^ cout4;
              count_d = '0;
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      carry_q     <= 1'b0;
      count_q     <= '0;
      sub_q       <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
      res_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus.ena) begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      sub_q       <= sub_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      cout_q      <= cout_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    bus.uo_out               = {idx_q, ovf_q, zero_q, res_q};
    bus.uio_out              = '0;
    bus.uio_out[UioBusy]     = (state_q == StRun);
    bus.uio_out[UioOutValid] = out_valid_q;
    bus.uio_out[UioDone]     = done_q;
    bus.uio_out[UioCarryOut] = cout_q;
    bus.uio_oe               = UioOeMask;
  end
endmodule
